fdc_sector_xfer: RTL and testbench

Parametrised sector data-path engine for the floppy controller. It buffers one sector between the CPU data port and the disk-image side, in either direction. It owns the byte counting, the RFM handshake and the overrun timeout that the controller core currently hard-codes for 512-byte sectors. The controller core issues `start` once command parameters are complete and consumes `done`/status to build ST0/ST1 results.

---
 rtl/fdc_sector_xfer.sv | 161 ++++++++++++++++
 tb/tb_fdc_sector_xfer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_sector_xfer.sv
// fdc_sector_xfer: one-sector buffer between the CPU data port and the disk-image side,
// handling byte counting, the RFM handshake and the overrun timeout in both directions.
module fdc_sector_xfer #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 2,
    parameter int OVR_W  = 9,
    parameter int OVR_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              dir_i,
    input  logic [2:0]        size_n_i,
    input  logic [7:0]        dtl_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [DATA_W-1:0] cpu_din_i,
    output logic [DATA_W-1:0] cpu_dout_o,
    output logic              rfm_o,
    input  logic              dsk_wr_i,
    input  logic [DATA_W-1:0] dsk_din_i,
    input  logic              dsk_rd_i,
    output logic [DATA_W-1:0] dsk_dout_o,
    output logic              commit_req_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic              aborted_o,
    output logic              size_err_o,
    output logic [MAX_N+7:0]  count_o
);
    localparam int CW = MAX_N + 8;
    localparam int AW = MAX_N + 7;

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, COLLECT, COMMIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d, len_q, len_d;
    logic [OVR_W-1:0]  tmr_q, tmr_d;
    logic              ovr_q, ovr_d, abt_q, abt_d, serr_q, serr_d;
    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [CW-1:0]     len_new;
    logic              tmr_full;
    logic [OVR_W-1:0]  tmr_inc;

    // N=0 sectors take their length from DTL, clamped to 128
    assign len_new  = (size_n_i == 3'd0) ? ((dtl_i == 8'd0 || dtl_i > 8'd128) ? CW'(128) : CW'(dtl_i))
                                         : CW'(128) << size_n_i;
    assign tmr_full = (OVR_EN != 0) && (&tmr_q);
    assign tmr_inc  = (&tmr_q) ? tmr_q : tmr_q + OVR_W'(1);

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        len_d     = len_q;
        tmr_d     = tmr_q;
        ovr_d     = ovr_q;
        abt_d     = abt_q;
        serr_d    = serr_q;
        mem_we    = 1'b0;
        mem_wdata = dsk_din_i;
        if (abort_i && state_q != IDLE && state_q != DONE) begin
            abt_d   = 1'b1;
            state_d = DONE;
        end else begin
            case (state_q)
                IDLE: if (start_i && !abort_i) begin
                    wptr_d  = '0;
                    rptr_d  = '0;
                    count_d = '0;
                    tmr_d   = '0;
                    ovr_d   = 1'b0;
                    abt_d   = 1'b0;
                    len_d   = len_new;
                    serr_d  = int'(size_n_i) > MAX_N;
                    state_d = serr_d ? DONE : (dir_i ? COLLECT : FILL);
                end
                FILL: if (dsk_wr_i) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + CW'(1);
                    if (wptr_d == len_q) state_d = DRAIN;
                end
                DRAIN: begin
                    tmr_d = tmr_inc;
                    if (cpu_rd_i) begin
                        rptr_d  = rptr_q + CW'(1);
                        count_d = count_q + CW'(1);
                        tmr_d   = '0;
                        if (count_d == len_q) state_d = DONE;
                    end else if (tmr_full) begin
                        ovr_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                COLLECT: begin
                    tmr_d = tmr_inc;
                    if (cpu_wr_i) begin
                        mem_we    = 1'b1;
                        mem_wdata = cpu_din_i;
                        wptr_d    = wptr_q + CW'(1);
                        count_d   = count_q + CW'(1);
                        tmr_d     = '0;
                        if (count_d == len_q) state_d = COMMIT;
                    end else if (tmr_full) begin
                        ovr_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                COMMIT: if (dsk_rd_i) begin
                    rptr_d = rptr_q + CW'(1);
                    if (rptr_d == len_q) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            tmr_q   <= '0;
            ovr_q   <= 1'b0;
            abt_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            len_q   <= len_d;
            tmr_q   <= tmr_d;
            ovr_q   <= ovr_d;
            abt_q   <= abt_d;
            serr_q  <= serr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q[AW-1:0]] <= mem_wdata;
    end

    assign cpu_dout_o   = mem[rptr_q[AW-1:0]];
    assign dsk_dout_o   = mem[rptr_q[AW-1:0]];
    assign rfm_o        = state_q == DRAIN || state_q == COLLECT;
    assign commit_req_o = state_q == COMMIT;
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign overrun_o    = ovr_q;
    assign aborted_o    = abt_q;
    assign size_err_o   = serr_q;
    assign count_o      = count_q;
endmodule

// File: tb/tb_fdc_sector_xfer.sv
// tb_fdc_sector_xfer: scoreboard bench; byte queues and done-status queue are filled by the
// stimulus and drained by a negedge monitor whenever the DUT accepts a strobe or pulses done.
module tb_fdc_sector_xfer;
    typedef struct packed {
        logic       ovr;
        logic       abt;
        logic       serr;
        logic [9:0] cnt;
    } res_t;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, dir = 1'b0;
    logic       cpu_rd = 1'b0, cpu_wr = 1'b0, dsk_wr = 1'b0, dsk_rd = 1'b0;
    logic [2:0] size_n = 3'd0;
    logic [7:0] dtl = 8'd0, cpu_din = 8'd0, dsk_din = 8'd0;
    logic [7:0] cpu_dout, dsk_dout, cpu_dout2, dsk_dout2;
    logic       rfm, commit_req, busy, done, overrun, aborted, size_err;
    logic       rfm2, commit_req2, busy2, done2, overrun2, aborted2, size_err2;
    logic [9:0] count, count2;

    int         tests = 0, fails = 0;
    logic [7:0] exp_cpu[$], exp_dsk[$];
    res_t       done_q[$];
    res_t       mon_e;
    bit         done2_seen = 1'b0;

    fdc_sector_xfer #(.DATA_W(8), .MAX_N(2), .OVR_W(9), .OVR_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .dir_i(dir),
        .size_n_i(size_n), .dtl_i(dtl), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr),
        .cpu_din_i(cpu_din), .cpu_dout_o(cpu_dout), .rfm_o(rfm), .dsk_wr_i(dsk_wr),
        .dsk_din_i(dsk_din), .dsk_rd_i(dsk_rd), .dsk_dout_o(dsk_dout),
        .commit_req_o(commit_req), .busy_o(busy), .done_o(done), .overrun_o(overrun),
        .aborted_o(aborted), .size_err_o(size_err), .count_o(count)
    );

    // Same stimulus, overrun detection disabled
    fdc_sector_xfer #(.DATA_W(8), .MAX_N(2), .OVR_W(9), .OVR_EN(0)) u_noovr (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .dir_i(dir),
        .size_n_i(size_n), .dtl_i(dtl), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr),
        .cpu_din_i(cpu_din), .cpu_dout_o(cpu_dout2), .rfm_o(rfm2), .dsk_wr_i(dsk_wr),
        .dsk_din_i(dsk_din), .dsk_rd_i(dsk_rd), .dsk_dout_o(dsk_dout2),
        .commit_req_o(commit_req2), .busy_o(busy2), .done_o(done2), .overrun_o(overrun2),
        .aborted_o(aborted2), .size_err_o(size_err2), .count_o(count2)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic int ref_len(int n, int d);
        if (n != 0) return 128 * (1 << n);
        return (d == 0 || d > 128) ? 128 : d;
    endfunction

    function automatic res_t mk(logic o, logic a, logic s, int c);
        return {o, a, s, 10'(c)};
    endfunction

    initial forever begin
        @(negedge clk);
        if (cpu_rd && rfm) begin
            if (exp_cpu.size() == 0) begin
                tests++; fails++;
                $display("FAIL cpu_dout: byte %0h popped, expected no pop", cpu_dout);
            end else check("cpu_dout", cpu_dout, exp_cpu.pop_front());
        end
        if (dsk_rd && commit_req) begin
            if (exp_dsk.size() == 0) begin
                tests++; fails++;
                $display("FAIL dsk_dout: byte %0h popped, expected no pop", dsk_dout);
            end else check("dsk_dout", dsk_dout, exp_dsk.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL done: pulse seen, expected none");
            end else begin
                mon_e = done_q.pop_front();
                check("done status {ovr,abt,serr,count}", {overrun, aborted, size_err, count}, mon_e);
            end
        end
        if (done2) done2_seen = 1'b1;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_xfer(logic d, int n, int l);
        exp_cpu.delete();
        exp_dsk.delete();
        dir = d; size_n = 3'(n); dtl = 8'(l); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic disk_push(logic [7:0] b);
        dsk_din = b; dsk_wr = 1'b1; exp_cpu.push_back(b);
        tick();
        dsk_wr = 1'b0;
    endtask

    task automatic cpu_push(logic [7:0] b);
        cpu_din = b; cpu_wr = 1'b1; exp_dsk.push_back(b);
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_pop(int gap);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        tick(gap);
    endtask

    task automatic dsk_pop(int gap);
        dsk_rd = 1'b1;
        tick();
        dsk_rd = 1'b0;
        tick(gap);
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((busy || done_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("transfer finished within budget", {31'd0, busy}, 0);
        check("pending done records", done_q.size(), 0);
    endtask

    task automatic read_xfer(int n, int l, int gmax);
        int len = ref_len(n, l);
        start_xfer(1'b0, n, l);
        check("read start busy", {31'd0, busy}, 1);
        check("read start count cleared", count, 0);
        check("read start flags cleared", {overrun, aborted, size_err}, 0);
        for (int i = 0; i < len; i++) disk_push(8'($urandom));
        done_q.push_back(mk(0, 0, 0, len));
        for (int i = 0; i < len; i++) cpu_pop($urandom_range(0, gmax));
        wait_idle(20);
        check("read final count", count, len);
    endtask

    task automatic write_xfer(int n, int l, int gmax);
        int len = ref_len(n, l);
        start_xfer(1'b1, n, l);
        check("write start rfm", {31'd0, rfm}, 1);
        check("write start count cleared", count, 0);
        for (int i = 0; i < len; i++) begin
            cpu_push(8'($urandom));
            tick($urandom_range(0, gmax));
        end
        check("write commit_req", {31'd0, commit_req}, 1);
        done_q.push_back(mk(0, 0, 0, len));
        for (int i = 0; i < len; i++) dsk_pop($urandom_range(0, gmax));
        wait_idle(20);
        check("write final count", count, len);
    endtask

    initial begin
        int first;
        tick(3);
        check("reset busy/rfm/commit/done", {busy, rfm, commit_req, done}, 0);
        check("reset flags", {overrun, aborted, size_err}, 0);
        check("reset count", count, 0);
        rst_n = 1'b1;
        tick();

        // Read N=2 with a counting pattern, 4-cycle CPU spacing
        start_xfer(1'b0, 2, 0);
        check("N2 busy after start", {31'd0, busy}, 1);
        check("N2 rfm during fill", {31'd0, rfm}, 0);
        for (int i = 0; i < 512; i++) begin
            if (i == 511) check("rfm before last fill byte", {31'd0, rfm}, 0);
            disk_push(8'(i));
            if (i == 100) begin
                cpu_rd = 1'b1;
                tick();
                cpu_rd = 1'b0;
            end
        end
        check("rfm after fill", {31'd0, rfm}, 1);
        check("count after fill", count, 0);
        done_q.push_back(mk(0, 0, 0, 512));
        for (int i = 0; i < 512; i++) begin
            if (i == 200) begin
                dsk_din = 8'($urandom); dsk_wr = 1'b1;
                tick();
                dsk_wr = 1'b0;
            end
            if (i == 300) begin
                dir = 1'b1; size_n = 3'd0; start = 1'b1;
                tick();
                start = 1'b0;
            end
            cpu_pop(i == 511 ? 0 : 3);
        end
        check("done right after last pop", {31'd0, done}, 1);
        check("busy in done cycle", {31'd0, busy}, 1);
        check("N2 count", count, 512);
        tick();
        check("busy low after done", {31'd0, busy}, 0);
        check("N2 no overrun", {31'd0, overrun}, 0);

        // Write N=1
        start_xfer(1'b1, 1, 0);
        check("write rfm after start", {31'd0, rfm}, 1);
        for (int i = 0; i < 256; i++) begin
            cpu_push(8'($urandom));
            if (i < 255) tick($urandom_range(0, 2));
        end
        check("commit_req after byte 256", {31'd0, commit_req}, 1);
        check("rfm low in commit", {31'd0, rfm}, 0);
        cpu_din = 8'hA5; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        done_q.push_back(mk(0, 0, 0, 256));
        for (int i = 0; i < 256; i++) dsk_pop($urandom_range(0, 2));
        wait_idle(20);

        // N=0 length rules
        read_xfer(0, 8'h20, 2);
        read_xfer(0, 0, 1);

        // Overrun, with the OVR_EN=0 copy watched in parallel
        start_xfer(1'b0, 0, 16);
        for (int i = 0; i < 16; i++) disk_push(8'($urandom));
        done_q.push_back(mk(1, 0, 0, 5));
        for (int i = 0; i < 5; i++) cpu_pop(0);
        done2_seen = 1'b0;
        first = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done && first < 0) first = i;
        end
        check("overrun latency near 511 cycles", {31'd0, first >= 505 && first <= 515}, 1);
        check("overrun flag", {31'd0, overrun}, 1);
        check("overrun count", count, 5);
        check("OVR_EN=0 no done", {31'd0, done2_seen}, 0);
        check("OVR_EN=0 still busy", {31'd0, busy2}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(2);
        check("OVR_EN=0 idle after abort", {31'd0, busy2}, 0);
        check("abort in idle ignored", {31'd0, aborted}, 0);

        // size_n beyond MAX_N
        done_q.push_back(mk(0, 0, 1, 0));
        start_xfer(1'b0, 3, 0);
        check("size_err done next cycle", {done, size_err, busy}, 3'b111);
        tick();
        check("size_err busy low", {31'd0, busy}, 0);

        // Abort mid-collect, then a clean read
        start_xfer(1'b1, 2, 0);
        for (int i = 0; i < 100; i++) cpu_push(8'($urandom));
        done_q.push_back(mk(0, 1, 0, 100));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort done next cycle", {done, aborted}, 2'b11);
        tick();
        check("idle after abort", {31'd0, busy}, 0);
        read_xfer(0, 8, 1);

        // abort+start together in idle
        dir = 1'b0; size_n = 3'd0; dtl = 8'd4; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort beats start", {31'd0, busy}, 0);
        tick(2);
        check("no done after abort+start", {31'd0, done}, 0);

        // Reset mid-drain
        start_xfer(1'b0, 0, 16);
        for (int i = 0; i < 16; i++) disk_push(8'($urandom));
        for (int i = 0; i < 3; i++) cpu_pop(1);
        rst_n = 1'b0;
        tick();
        check("reset mid-drain outputs", {busy, rfm, commit_req, done, overrun, aborted, size_err}, 0);
        check("reset mid-drain count", count, 0);
        rst_n = 1'b1;
        exp_cpu.delete();
        tick();

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1) write_xfer($urandom_range(0, 2), $urandom_range(0, 255), 3);
            else read_xfer($urandom_range(0, 2), $urandom_range(0, 255), 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
